// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store controller.
// Size encodings, FSM states and byte-lane masks.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_RMW_WR,
    S_WR,
    S_RESP
  } state_e;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic bad_align(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == 2'd3) ||
           (size == SZ_H && off[0]) ||
           (size == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract/extend and store merge.
// Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  logic [31:0] rsh;
  logic [31:0] wsh;
  logic [3:0]  mask;

  always_comb begin
    rsh = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B: ld_data_o = {{24{sign_i & rsh[7]}}, rsh[7:0]};
      SZ_H: ld_data_o = {{16{sign_i & rsh[15]}}, rsh[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

  always_comb begin
    wsh  = wdata_i << {off_i, 3'b000};
    mask = lane_mask(size_i, off_i);
    st_data_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) st_data_o[8*i +: 8] = wsh[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for a word-only data RAM.
// Sub-word stores run as read-modify-write.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_AW    = 8,
  parameter bit          RANGE_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [31:0] AMASK =
    32'((64'd1 << (RAM_AW + 2)) - 64'd1) & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic        we_q, sign_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] merge_q, rdata_q;
  logic [31:0] ld_data, st_data;
  logic        oor, err_in, accept;

  assign oor    = (req_addr >> (RAM_AW + 2)) != 32'd0;
  assign err_in = bad_align(req_size, req_addr[1:0]) ||
                  (RANGE_CHK && oor);
  assign accept = req_valid && req_ready;

  lsu_lane_align u_align (
    .size_i   (size_q),
    .sign_i   (sign_q),
    .off_i    (addr_q[1:0]),
    .rdata_i  (ram_rdata),
    .wdata_i  (wdata_q),
    .old_i    (merge_q),
    .ld_data_o(ld_data),
    .st_data_o(st_data)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_en    = 1'b0;
    ram_rw    = 1'b0;
    ram_wdata = 32'd0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err_in)           state_d = S_RESP;
          else if (!req_we)     state_d = S_RD;
          else if (req_size == SZ_W) state_d = S_WR;
          else                  state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        ram_en  = 1'b1;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        ram_en  = 1'b1;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        ram_en    = 1'b1;
        ram_rw    = 1'b1;
        ram_wdata = st_data;
        state_d   = S_RESP;
      end
      S_WR: begin
        ram_en    = 1'b1;
        ram_rw    = 1'b1;
        ram_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr  = addr_q & AMASK;
  assign rsp_err   = (state_q == S_RESP) && err_q;
  assign rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        err_q   <= err_in;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'd0;
      end
      // ram_rdata is only trusted while a read is driven
      if (state_q == S_RD)     rdata_q <= ld_data;
      if (state_q == S_RMW_RD) merge_q <= ram_rdata;
    end
  end

endmodule
